cci_mpf_shim_buffer_n: RTL and testbench

CCI_MPF_SHIM_BUFFER_N -- requirements
Module: cci_mpf_shim_buffer_n

---
 rtl/cci_mpf_shim_buffer_n.sv | 202 ++++++++++++++++++++
 tb/tb_cci_mpf_shim_buffer_n.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_shim_buffer_n.sv
// ---------------------------------------------------------------------------
// cci_mpf_shim_buffer_n
//
// Purpose: buffers requests from N_CHANNELS senders in per-channel FIFOs and
// merges them onto a single registered output stream. A round-robin arbiter
// picks the channel. Each channel also limits how many of its requests may be
// outstanding at once; rsp_retire pulses free those slots again.
//
// Ports:
//   clk             sole clock
//   reset_n         asynchronous active-low reset
//   in_valid[i]     request strobe for channel i
//   in_data         channel i payload in [i*DATA_WIDTH +: DATA_WIDTH]
//   in_almost_full  per-channel registered flow control back to the sender
//   out_almost_full downstream flow control; when high, nothing is granted
//   out_valid       registered merged request strobe
//   out_data        registered payload of the granted request
//   out_chan        source channel of out_data
//   rsp_retire[i]   retires one outstanding request of channel i
//   err_overflow[i] sticky flag: a push to a full FIFO i was dropped
//
// Optional feature (macro MPF_BUFFER_STATS_EN):
//   stat_hwm        per-channel peak occupancy, clog2(DEPTH+1) bits each
//   stat_stall      per-channel saturating count of cycles non-empty but not
//                   granted, 16 bits each
// ---------------------------------------------------------------------------
module cci_mpf_shim_buffer_n #(
    parameter int N_CHANNELS            = 2,
    parameter int DATA_WIDTH            = 64,
    parameter int DEPTH                 = 8,
    parameter int ALMOST_FULL_THRESHOLD = 2,
    parameter int MAX_ACTIVE_REQS       = 128
) (
    input  logic                                              clk,
    input  logic                                              reset_n,
    input  logic [N_CHANNELS-1:0]                             in_valid,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0]                  in_data,
    output logic [N_CHANNELS-1:0]                             in_almost_full,
    input  logic                                              out_almost_full,
    output logic                                              out_valid,
    output logic [DATA_WIDTH-1:0]                             out_data,
    output logic [((N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1)-1:0] out_chan,
    input  logic [N_CHANNELS-1:0]                             rsp_retire,
    output logic [N_CHANNELS-1:0]                             err_overflow
`ifdef MPF_BUFFER_STATS_EN
    ,
    output logic [N_CHANNELS*$clog2(DEPTH+1)-1:0]             stat_hwm,
    output logic [N_CHANNELS*16-1:0]                          stat_stall
`endif
);

    localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int KW = $clog2(MAX_ACTIVE_REQS + 1);

    localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
    localparam logic [OW-1:0] OCC_AF   = OW'(DEPTH - ALMOST_FULL_THRESHOLD);
    localparam logic [KW-1:0] ACT_MAX  = KW'(MAX_ACTIVE_REQS);

    logic [N_CHANNELS-1:0] w_elig;
    logic [N_CHANNELS-1:0] w_grant_oh;
    logic                  w_grant_vld;
    logic [CW-1:0]         w_grant_idx;
    logic [DATA_WIDTH-1:0] w_head [N_CHANNELS];

    logic [CW-1:0]         r_last_grant;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CW-1:0]         r_out_chan;

    // Round-robin: offset k=1 is the channel right after the last winner, so
    // the first eligible channel met while walking k upward wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_grant_oh  = '0;
        for (int k = 1; k <= N_CHANNELS; k++) begin
            for (int j = 0; j < N_CHANNELS; j++) begin
                if (!w_grant_vld && w_elig[j] &&
                    (j == ((int'(r_last_grant) + k) % N_CHANNELS))) begin
                    w_grant_vld   = 1'b1;
                    w_grant_idx   = CW'(j);
                    w_grant_oh[j] = 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_chan
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [AW-1:0]         r_wr_ptr;
        logic [AW-1:0]         r_rd_ptr;
        logic [OW-1:0]         r_occ;
        logic [OW-1:0]         w_occ_next;
        logic [KW-1:0]         r_act;
        logic                  r_af;
        logic                  r_err;
        logic                  w_push;
        logic                  w_pop;
        logic                  w_retire;

        assign w_pop    = w_grant_oh[gi];
        // A full FIFO still accepts a push when its head leaves this cycle.
        assign w_push   = in_valid[gi] && ((r_occ != OCC_FULL) || w_pop);
        // Retiring with nothing outstanding is meaningless and ignored.
        assign w_retire = rsp_retire[gi] && (r_act != '0);
        assign w_elig[gi] = (r_occ != '0) && (r_act < ACT_MAX) && !out_almost_full;
        assign w_head[gi] = r_mem[r_rd_ptr];

        assign in_almost_full[gi] = r_af;
        assign err_overflow[gi]   = r_err;

        always_comb begin
            w_occ_next = r_occ;
            if (w_push && !w_pop) begin
                w_occ_next = r_occ + OW'(1);
            end else if (!w_push && w_pop) begin
                w_occ_next = r_occ - OW'(1);
            end
        end

        // Storage needs no reset: the pointers and occupancy define validity.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_occ    <= '0;
                r_act    <= '0;
                r_af     <= 1'b0;
                r_err    <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_occ <= w_occ_next;
                r_af  <= (w_occ_next >= OCC_AF);
                if (in_valid[gi] && !w_push) begin
                    r_err <= 1'b1;
                end
                if (w_pop && !w_retire) begin
                    r_act <= r_act + KW'(1);
                end else if (!w_pop && w_retire) begin
                    r_act <= r_act - KW'(1);
                end
            end
        end

`ifdef MPF_BUFFER_STATS_EN
        logic [OW-1:0] r_hwm;
        logic [15:0]   r_stall;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_hwm   <= '0;
                r_stall <= '0;
            end else begin
                if (w_occ_next > r_hwm) begin
                    r_hwm <= w_occ_next;
                end
                if ((r_occ != '0) && !w_pop && (r_stall != 16'hFFFF)) begin
                    r_stall <= r_stall + 16'd1;
                end
            end
        end

        assign stat_hwm[gi*OW +: OW]   = r_hwm;
        assign stat_stall[gi*16 +: 16] = r_stall;
`endif
    end

    // Output stage: data and channel hold their last value when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_chan   <= '0;
            r_last_grant <= CW'(N_CHANNELS - 1);
        end else begin
            r_out_valid <= w_grant_vld;
            if (w_grant_vld) begin
                r_out_data   <= w_head[w_grant_idx];
                r_out_chan   <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_cci_mpf_shim_buffer_n.sv
// ---------------------------------------------------------------------------
// tb_cci_mpf_shim_buffer_n
//
// Directed bench for cci_mpf_shim_buffer_n (N_CHANNELS=2, DEPTH=8,
// threshold 2, MAX_ACTIVE_REQS=2). A queue-based model tracks the expected
// outputs and is compared on every clock cycle; directed sections add literal
// expectations for the single-push latency, fairness, flow control, the
// outstanding limit, and reset. The stats check is built only when
// MPF_BUFFER_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_cci_mpf_shim_buffer_n;

    localparam int N     = 2;
    localparam int W     = 64;
    localparam int DEPTH = 8;
    localparam int THR   = 2;
    localparam int MAXA  = 2;
    localparam int OW    = $clog2(DEPTH + 1);

    logic           clk        = 1'b0;
    logic           reset_n    = 1'b0;
    logic [N-1:0]   in_valid   = '0;
    logic [N*W-1:0] in_data    = '0;
    logic [N-1:0]   in_af;
    logic           oaf        = 1'b0;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [0:0]     out_chan;
    logic [N-1:0]   rsp_retire = '0;
    logic [N-1:0]   err;
`ifdef MPF_BUFFER_STATS_EN
    logic [N*OW-1:0] stat_hwm;
    logic [N*16-1:0] stat_stall;
`endif

    always #5 clk = ~clk;

    cci_mpf_shim_buffer_n #(
        .N_CHANNELS            (N),
        .DATA_WIDTH            (W),
        .DEPTH                 (DEPTH),
        .ALMOST_FULL_THRESHOLD (THR),
        .MAX_ACTIVE_REQS       (MAXA)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_almost_full  (in_af),
        .out_almost_full (oaf),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_chan        (out_chan),
        .rsp_retire      (rsp_retire),
        .err_overflow    (err)
`ifdef MPF_BUFFER_STATS_EN
        ,
        .stat_hwm        (stat_hwm),
        .stat_stall      (stat_stall)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: one queue per channel plus outstanding counts.
    // ------------------------------------------------------------------
    logic [W-1:0] mq [N][$];
    int           m_act [N];
    int           m_last = N - 1;
    logic         m_ov   = 1'b0;
    logic [W-1:0] m_od   = '0;
    int           m_oc   = 0;
    logic [N-1:0] m_af   = '0;
    logic [N-1:0] m_err  = '0;

    task automatic model_clear();
        for (int c = 0; c < N; c++) begin
            mq[c].delete();
            m_act[c] = 0;
        end
        m_last = N - 1;
        m_ov   = 1'b0;
        m_od   = '0;
        m_oc   = 0;
        m_af   = '0;
        m_err  = '0;
    endtask

    task automatic model_step();
        bit gv;
        int gc;
        int occ [N];
        bit g;
        bit r;
        gv = 1'b0;
        gc = 0;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (!gv && mq[c].size() > 0 && m_act[c] < MAXA && !oaf) begin
                gv = 1'b1;
                gc = c;
            end
        end
        for (int c = 0; c < N; c++) occ[c] = mq[c].size();
        if (gv) begin
            m_ov   = 1'b1;
            m_od   = mq[gc].pop_front();
            m_oc   = gc;
            m_last = gc;
        end else begin
            m_ov = 1'b0;
        end
        for (int c = 0; c < N; c++) begin
            g = gv && (gc == c);
            if (in_valid[c]) begin
                if (occ[c] < DEPTH || g) mq[c].push_back(in_data[c*W +: W]);
                else m_err[c] = 1'b1;
            end
            m_af[c]  = (mq[c].size() >= DEPTH - THR);
            r        = rsp_retire[c] && (m_act[c] > 0);
            m_act[c] = m_act[c] + int'(g) - int'(r);
        end
    endtask

    always @(negedge reset_n) model_clear();
    always @(posedge clk) if (reset_n === 1'b1) model_step();

    // ------------------------------------------------------------------
    // Per-cycle compare, output log and optional automatic retire.
    // ------------------------------------------------------------------
    logic [W-1:0] log_data [$];
    int           log_chan [$];
    logic         auto_ret = 1'b0;
    logic [N-1:0] ret_pend = '0;

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            chk("cyc_out_valid", 64'(out_valid), 64'(m_ov));
            if (m_ov && out_valid) begin
                chk("cyc_out_data", out_data, m_od);
                chk("cyc_out_chan", 64'(out_chan), 64'(m_oc));
            end
            chk("cyc_in_almost_full", 64'(in_af), 64'(m_af));
            chk("cyc_err_overflow", 64'(err), 64'(m_err));
            if (out_valid) begin
                log_data.push_back(out_data);
                log_chan.push_back(int'(out_chan));
                $display("txn t=%0t chan=%0d data=%0h", $time, out_chan, out_data);
                if (auto_ret) ret_pend[out_chan] = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (auto_ret) begin
                rsp_retire = ret_pend;
                ret_pend   = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        in_valid   = '0;
        oaf        = 1'b0;
        rsp_retire = '0;
        auto_ret   = 1'b0;
        ret_pend   = '0;
        tick();
        tick();
        reset_n = 1'b1;
        log_data.delete();
        log_chan.delete();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_chan", 64'(out_chan), 64'd0);
        chk("rst_in_almost_full", 64'(in_af), 64'd0);
        chk("rst_err_overflow", 64'(err), 64'd0);
        reset_n = 1'b1;

        // Single push: out_valid two cycles after in_valid
        in_valid = 2'b01;
        in_data[0 +: W] = 64'hA5;
        tick();
        in_valid = '0;
        chk("single_t1_valid", 64'(out_valid), 64'd0);
        tick();
        chk("single_t2_valid", 64'(out_valid), 64'd1);
        chk("single_t2_data", out_data, 64'hA5);
        chk("single_t2_chan", 64'(out_chan), 64'd0);
        tick();

        // Both channels push 4 entries: strict alternation, order kept
        do_reset();
        auto_ret = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 2'b11;
            in_data  = {64'h200 + 64'(k), 64'h100 + 64'(k)};
            tick();
        end
        in_valid = '0;
        repeat (12) tick();
        chk("rr_count", 64'(log_data.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < log_data.size()) begin
                chk("rr_chan", 64'(log_chan[i]), 64'(i % 2));
                chk("rr_data", log_data[i], ((i % 2) ? 64'h200 : 64'h100) + 64'(i / 2));
            end
        end

        // Flow control and overflow on channel 1 with downstream stalled
        do_reset();
        auto_ret = 1'b1;
        oaf      = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            in_valid = 2'b10;
            in_data[W +: W] = 64'h300 + 64'(k - 1);
            tick();
            if (k == 5) chk("af_after5", 64'(in_af[1]), 64'd0);
            if (k == 6) chk("af_after6", 64'(in_af[1]), 64'd1);
            if (k == 8) chk("err_after8", 64'(err[1]), 64'd0);
            if (k == 9) chk("err_after9", 64'(err[1]), 64'd1);
        end
        in_valid = '0;
        oaf      = 1'b0;
        repeat (40) tick();
        chk("ovf_drain_count", 64'(log_data.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < log_data.size()) begin
                chk("ovf_drain_data", log_data[i], 64'h300 + 64'(i));
                chk("ovf_drain_chan", 64'(log_chan[i]), 64'd1);
            end
        end
        chk("ovf_err_sticky", 64'(err), 64'h2);
        chk("ovf_af_clear", 64'(in_af), 64'd0);

        // Outstanding limit of 2 on channel 0
        do_reset();
        for (int k = 0; k < 3; k++) begin
            in_valid = 2'b01;
            in_data[0 +: W] = 64'h400 + 64'(k);
            tick();
        end
        in_valid = '0;
        repeat (8) tick();
        chk("lim_issued", 64'(log_data.size()), 64'd2);
        rsp_retire = 2'b01;
        tick();
        rsp_retire = '0;
        chk("lim_retire_cycle_valid", 64'(out_valid), 64'd0);
        chk("lim_hold_data", out_data, 64'h401);
        tick();
        chk("lim_third_valid", 64'(out_valid), 64'd1);
        chk("lim_third_data", out_data, 64'h402);
        chk("lim_third_chan", 64'(out_chan), 64'd0);

        // Reset with 5 entries buffered
        do_reset();
        oaf = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 2'b01;
            in_data[0 +: W] = 64'h500 + 64'(k);
            tick();
        end
        in_valid = '0;
        chk("mid_af_full6", 64'(in_af[0]), 64'd1);
        oaf = 1'b0;
        tick();
        oaf = 1'b1;
        chk("mid_pre_valid", 64'(out_valid), 64'd1);
        chk("mid_pre_data", out_data, 64'h500);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        chk("mid_rst_chan", 64'(out_chan), 64'd0);
        chk("mid_rst_af", 64'(in_af), 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        log_data.delete();
        log_chan.delete();
        tick();
        tick();
        reset_n = 1'b1;
        oaf     = 1'b0;
        repeat (10) tick();
        chk("mid_no_output", 64'(log_data.size()), 64'd0);

`ifdef MPF_BUFFER_STATS_EN
        // Stats: 5 pushes, FIFO non-empty and stalled for 10 cycles
        do_reset();
        oaf = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 2'b01;
            in_data[0 +: W] = 64'h600 + 64'(k);
            tick();
        end
        in_valid = '0;
        repeat (6) tick();
        chk("stat_hwm0", 64'(stat_hwm[0 +: OW]), 64'd5);
        chk("stat_stall0", 64'(stat_stall[0 +: 16]), 64'd10);
        chk("stat_stall1", 64'(stat_stall[16 +: 16]), 64'd0);
        oaf = 1'b0;
        repeat (4) tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
